instruction_fetch: RTL and testbench

//  Fetch stage directly downstream of the 16-bit program counter. Samples the PC value,

---
 rtl/instruction_fetch_pkg.sv | 33 +++
 rtl/instruction_fetch_wait_timer.sv | 49 ++++
 rtl/instruction_fetch.sv | 241 ++++++++++++++++++++++++
 tb/tb_instruction_fetch.sv | 325 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/instruction_fetch_pkg.sv
// -----------------------------------------------------------------------------
// instruction_fetch_pkg
// Shared definitions for the instruction fetch stage.
//  - Include-guarded shared header block: `define state codes S_IDLE/S_ADDR/
//    S_READ/S_HOLD (2 bits) and the default bus widths / timeout.
//  - Package: FSM state enum built from those codes, default parameter values.
// No ports (package only).
// -----------------------------------------------------------------------------
`ifndef IFETCH_DEFS_V
`define IFETCH_DEFS_V
`define S_IDLE              2'd0
`define S_ADDR              2'd1
`define S_READ              2'd2
`define S_HOLD              2'd3
`define IFETCH_DATA_WIDTH   16
`define IFETCH_ADDR_WIDTH   16
`define IFETCH_MAX_WAIT     15
`endif

package instruction_fetch_pkg;

    typedef enum logic [1:0] {
        S_IDLE = `S_IDLE,
        S_ADDR = `S_ADDR,
        S_READ = `S_READ,
        S_HOLD = `S_HOLD
    } ifetch_state_t;

    localparam int DEFAULT_DATA_WIDTH = `IFETCH_DATA_WIDTH;
    localparam int DEFAULT_ADDR_WIDTH = `IFETCH_ADDR_WIDTH;
    localparam int DEFAULT_MAX_WAIT   = `IFETCH_MAX_WAIT;

endpackage

// File: rtl/instruction_fetch_wait_timer.sv
// -----------------------------------------------------------------------------
// ifetch_wait_timer
// Counts memory-read wait cycles and flags a bus timeout.
//  clock    in  : rising-edge clock
//  reset    in  : synchronous, active-high
//  clear    in  : zero the count (held while not waiting for a read)
//  enable   in  : one more cycle spent waiting without an acknowledge
//  expired  out : this is the MAX_WAIT-th waiting cycle (never when MAX_WAIT=0)
// -----------------------------------------------------------------------------
module ifetch_wait_timer #(
    parameter int MAX_WAIT = 15
) (
    input  logic clock,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int CW = (MAX_WAIT > 1) ? $clog2(MAX_WAIT + 1) : 1;
    localparam logic [CW-1:0] LAST = CW'((MAX_WAIT > 0) ? (MAX_WAIT - 1) : 0);
    localparam bit TIMEOUT_ON = (MAX_WAIT != 0);

    logic [CW-1:0] count_r;

    // Wait-cycle counter: holds the number of completed waiting cycles.
    always_ff @(posedge clock) begin
        if (reset) begin
            count_r <= '0;
        end else if (clear) begin
            count_r <= '0;
        end else if (enable) begin
            count_r <= count_r + CW'(1);
        end else begin
            count_r <= count_r;
        end
    end

    // The current cycle is the last one allowed: counting started at zero.
    always_comb begin
        expired = 1'b0;
        if (TIMEOUT_ON && enable && (count_r == LAST)) begin
            expired = 1'b1;
        end else begin
            expired = 1'b0;
        end
    end

endmodule

// File: rtl/instruction_fetch.sv
// -----------------------------------------------------------------------------
// instruction_fetch
// Fetch stage behind the program counter: samples pc_in, runs a read
// handshake on the memory bus, captures the returned word into the
// instruction register and offers it to the decoder over valid/ready.
// Optional feature macro: IFETCH_PREFETCH_EN (2-entry instruction queue).
//  clock, reset       : rising-edge clock, synchronous active-high reset
//  run                : level, keep fetching while 1
//  flush              : 1-cycle pulse, PC was reloaded; drop current work
//  pc_in              : current PC value
//  pc_inc             : 1-cycle PC count enable per accepted memory word
//  mem_addr, mem_rd   : registered read address / request (held until ack)
//  mem_ack, mem_data  : read data valid / read data
//  ir_out, ir_valid   : instruction word to decoder and its valid flag
//  ir_ready           : decoder accepts ir_out when ir_valid && ir_ready
//  bus_err            : sticky read-timeout flag, cleared only by reset
// -----------------------------------------------------------------------------
module instruction_fetch
    import instruction_fetch_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH,
    parameter int MAX_WAIT   = DEFAULT_MAX_WAIT
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  run,
    input  logic                  flush,
    input  logic [ADDR_WIDTH-1:0] pc_in,
    output logic                  pc_inc,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic                  mem_rd,
    input  logic                  mem_ack,
    input  logic [DATA_WIDTH-1:0] mem_data,
    output logic [DATA_WIDTH-1:0] ir_out,
    output logic                  ir_valid,
    input  logic                  ir_ready,
    output logic                  bus_err
);

    ifetch_state_t         state_r;
    ifetch_state_t         next_state_s;
    logic [ADDR_WIDTH-1:0] mem_addr_r;
    logic                  mem_rd_r;
    logic                  pc_inc_r;
    logic                  bus_err_r;
    logic                  ir_valid_s;
    logic                  deq_s;
    logic                  load_s;
    logic                  hold_after_load_s;
    logic                  timer_clr_s;
    logic                  timer_en_s;
    logic                  expired_s;

    ifetch_wait_timer #(
        .MAX_WAIT (MAX_WAIT)
    ) u_wait_timer (
        .clock   (clock),
        .reset   (reset),
        .clear   (timer_clr_s),
        .enable  (timer_en_s),
        .expired (expired_s)
    );

    // A word leaves the IR whenever the decoder handshakes, in any state.
    assign deq_s = ir_valid_s && ir_ready;

    // FSM state register.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_r <= S_IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // FSM next-state logic; flush overrides every state.
    always_comb begin
        next_state_s = state_r;
        if (flush) begin
            next_state_s = S_ADDR;
        end else begin
            case (state_r)
                S_IDLE: begin
                    if (run && !bus_err_r) next_state_s = S_ADDR;
                    else                   next_state_s = S_IDLE;
                end
                S_ADDR: begin
                    if (run) next_state_s = S_READ;
                    else     next_state_s = S_IDLE;
                end
                S_READ: begin
                    // An acknowledge on the last allowed cycle still wins.
                    if (mem_ack)        next_state_s = hold_after_load_s ? S_HOLD : S_ADDR;
                    else if (expired_s) next_state_s = S_IDLE;
                    else                next_state_s = S_READ;
                end
                S_HOLD: begin
                    if (deq_s) next_state_s = S_ADDR;
                    else       next_state_s = S_HOLD;
                end
                default: next_state_s = S_IDLE;
            endcase
        end
    end

    // FSM control strobes: IR load and wait-timer control.
    always_comb begin
        load_s      = 1'b0;
        timer_en_s  = 1'b0;
        timer_clr_s = 1'b1;
        case (state_r)
            S_READ: begin
                load_s      = mem_ack && !flush;
                timer_en_s  = !mem_ack && !flush;
                timer_clr_s = flush;
            end
            S_IDLE, S_ADDR, S_HOLD: begin
                load_s      = 1'b0;
                timer_en_s  = 1'b0;
                timer_clr_s = 1'b1;
            end
            default: begin
                load_s      = 1'b0;
                timer_en_s  = 1'b0;
                timer_clr_s = 1'b1;
            end
        endcase
    end

    // Memory address: sampled from the PC only in S_ADDR, stable during S_READ.
    always_ff @(posedge clock) begin
        if (reset) begin
            mem_addr_r <= '0;
        end else if (state_r == S_ADDR) begin
            mem_addr_r <= pc_in;
        end else begin
            mem_addr_r <= mem_addr_r;
        end
    end

    // Read request, PC increment pulse and sticky timeout flag.
    always_ff @(posedge clock) begin
        if (reset) begin
            mem_rd_r  <= 1'b0;
            pc_inc_r  <= 1'b0;
            bus_err_r <= 1'b0;
        end else begin
            mem_rd_r  <= (next_state_s == S_READ);
            pc_inc_r  <= load_s;
            bus_err_r <= bus_err_r || (expired_s && !flush);
        end
    end

`ifdef IFETCH_PREFETCH_EN
    logic [DATA_WIDTH-1:0] q0_r;
    logic [DATA_WIDTH-1:0] q1_r;
    logic [1:0]            q_count_r;

    // Stop fetching only when this load fills the second slot.
    assign hold_after_load_s = (q_count_r == 2'd2) || ((q_count_r == 2'd1) && !deq_s);
    assign ir_valid_s        = (q_count_r != 2'd0);

    // Two-entry instruction queue; q0_r is always the head.
    always_ff @(posedge clock) begin
        if (reset) begin
            q0_r      <= '0;
            q1_r      <= '0;
            q_count_r <= 2'd0;
        end else if (flush) begin
            q0_r      <= q0_r;
            q1_r      <= q1_r;
            q_count_r <= 2'd0;
        end else begin
            case ({load_s, deq_s})
                2'b10: begin
                    if (q_count_r == 2'd0) q0_r <= mem_data;
                    else                   q1_r <= mem_data;
                    q_count_r <= q_count_r + 2'd1;
                end
                2'b01: begin
                    q0_r      <= q1_r;
                    q_count_r <= q_count_r - 2'd1;
                end
                2'b11: begin
                    // Head leaves and the new word joins behind whatever is left.
                    if (q_count_r == 2'd1) begin
                        q0_r <= mem_data;
                    end else begin
                        q0_r <= q1_r;
                        q1_r <= mem_data;
                    end
                    q_count_r <= q_count_r;
                end
                default: begin
                    q0_r      <= q0_r;
                    q1_r      <= q1_r;
                    q_count_r <= q_count_r;
                end
            endcase
        end
    end

    assign ir_out = q0_r;
`else
    logic [DATA_WIDTH-1:0] ir_r;
    logic                  ir_valid_r;

    assign hold_after_load_s = 1'b1;
    assign ir_valid_s        = ir_valid_r;

    // Single instruction register and its valid flag.
    always_ff @(posedge clock) begin
        if (reset) begin
            ir_r       <= '0;
            ir_valid_r <= 1'b0;
        end else if (flush) begin
            ir_r       <= ir_r;
            ir_valid_r <= 1'b0;
        end else if (load_s) begin
            ir_r       <= mem_data;
            ir_valid_r <= 1'b1;
        end else if (deq_s) begin
            ir_r       <= ir_r;
            ir_valid_r <= 1'b0;
        end else begin
            ir_r       <= ir_r;
            ir_valid_r <= ir_valid_r;
        end
    end

    assign ir_out = ir_r;
`endif

    assign ir_valid = ir_valid_s;
    assign mem_addr = mem_addr_r;
    assign mem_rd   = mem_rd_r;
    assign pc_inc   = pc_inc_r;
    assign bus_err  = bus_err_r;

endmodule

// File: tb/tb_instruction_fetch.sv
// -----------------------------------------------------------------------------
// tb_instruction_fetch
// Self-checking bench for instruction_fetch (MAX_WAIT = 4). Directed
// scenarios plus a randomized run scored against a transaction-level model:
// a queue of words the memory handed over, checked against what the decoder
// accepts, together with address / request / PC-increment rules.
// -----------------------------------------------------------------------------
module tb_instruction_fetch;

`ifdef IFETCH_PREFETCH_EN
    localparam int CAP = 2;
`else
    localparam int CAP = 1;
`endif

    logic        clock;
    logic        reset;
    logic        run;
    logic        flush;
    logic [15:0] pc_in;
    logic        pc_inc;
    logic [15:0] mem_addr;
    logic        mem_rd;
    logic        mem_ack;
    logic [15:0] mem_data;
    logic [15:0] ir_out;
    logic        ir_valid;
    logic        ir_ready;
    logic        bus_err;

    int n_checks = 0;
    int n_fail   = 0;

    instruction_fetch #(
        .DATA_WIDTH (16),
        .ADDR_WIDTH (16),
        .MAX_WAIT   (4)
    ) dut (
        .clock    (clock),
        .reset    (reset),
        .run      (run),
        .flush    (flush),
        .pc_in    (pc_in),
        .pc_inc   (pc_inc),
        .mem_addr (mem_addr),
        .mem_rd   (mem_rd),
        .mem_ack  (mem_ack),
        .mem_data (mem_data),
        .ir_out   (ir_out),
        .ir_valid (ir_valid),
        .ir_ready (ir_ready),
        .bus_err  (bus_err)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Hold reset over two rising edges; returns at a falling edge with reset low.
    task automatic do_reset();
        reset    = 1'b1;
        run      = 1'b0;
        flush    = 1'b0;
        mem_ack  = 1'b0;
        mem_data = 16'h0000;
        ir_ready = 1'b0;
        pc_in    = 16'h0000;
        @(negedge clock);
        @(negedge clock);
        reset = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        run = 1'b1;
        repeat (8) @(negedge clock);
        n_checks++; if (bus_err !== 1'b1) begin n_fail++; $display("FAIL rst_pre_bus_err got %0b want 1", bus_err); end
        do_reset();
        n_checks++; if (pc_inc !== 1'b0)       begin n_fail++; $display("FAIL rst_pc_inc got %0b want 0", pc_inc); end
        n_checks++; if (mem_addr !== 16'h0000) begin n_fail++; $display("FAIL rst_mem_addr got %h want 0000", mem_addr); end
        n_checks++; if (mem_rd !== 1'b0)       begin n_fail++; $display("FAIL rst_mem_rd got %0b want 0", mem_rd); end
        n_checks++; if (ir_out !== 16'h0000)   begin n_fail++; $display("FAIL rst_ir_out got %h want 0000", ir_out); end
        n_checks++; if (ir_valid !== 1'b0)     begin n_fail++; $display("FAIL rst_ir_valid got %0b want 0", ir_valid); end
        n_checks++; if (bus_err !== 1'b0)      begin n_fail++; $display("FAIL rst_bus_err got %0b want 0", bus_err); end
    endtask

    task automatic test_single_fetch();
        do_reset();
        run = 1'b1; pc_in = 16'h0100;                     // cycle 0
        @(negedge clock);                                  // cycle 1
        n_checks++; if (mem_rd !== 1'b0) begin n_fail++; $display("FAIL t1_c1_mem_rd got %0b want 0", mem_rd); end
        @(negedge clock);                                  // cycle 2
        n_checks++; if (mem_rd !== 1'b1)       begin n_fail++; $display("FAIL t1_c2_mem_rd got %0b want 1", mem_rd); end
        n_checks++; if (mem_addr !== 16'h0100) begin n_fail++; $display("FAIL t1_c2_mem_addr got %h want 0100", mem_addr); end
        mem_ack = 1'b1; mem_data = 16'hA5A5;
        @(negedge clock);                                  // cycle 3
        mem_ack = 1'b0;
        n_checks++; if (ir_valid !== 1'b1)   begin n_fail++; $display("FAIL t1_c3_ir_valid got %0b want 1", ir_valid); end
        n_checks++; if (ir_out !== 16'hA5A5) begin n_fail++; $display("FAIL t1_c3_ir_out got %h want a5a5", ir_out); end
        n_checks++; if (pc_inc !== 1'b1)     begin n_fail++; $display("FAIL t1_c3_pc_inc got %0b want 1", pc_inc); end
        @(negedge clock);                                  // cycle 4
        n_checks++; if (pc_inc !== 1'b0)     begin n_fail++; $display("FAIL t1_c4_pc_inc got %0b want 0", pc_inc); end
        n_checks++; if (ir_valid !== 1'b1)   begin n_fail++; $display("FAIL t1_c4_ir_valid got %0b want 1", ir_valid); end
    endtask

`ifndef IFETCH_PREFETCH_EN
    // Continues from test_single_fetch: decoder stalls, then accepts.
    task automatic test_hold();
        for (int i = 0; i < 5; i++) begin
            @(negedge clock);
            n_checks++; if (ir_out !== 16'hA5A5) begin n_fail++; $display("FAIL t2_stall_ir_out cyc %0d got %h want a5a5", i, ir_out); end
            n_checks++; if (mem_rd !== 1'b0)     begin n_fail++; $display("FAIL t2_stall_mem_rd cyc %0d got %0b want 0", i, mem_rd); end
            n_checks++; if (pc_inc !== 1'b0)     begin n_fail++; $display("FAIL t2_stall_pc_inc cyc %0d got %0b want 0", i, pc_inc); end
        end
        ir_ready = 1'b1; pc_in = 16'h0101;
        @(negedge clock);
        ir_ready = 1'b0;
        n_checks++; if (ir_valid !== 1'b0) begin n_fail++; $display("FAIL t2_consumed_ir_valid got %0b want 0", ir_valid); end
        @(negedge clock);
        n_checks++; if (mem_rd !== 1'b1)       begin n_fail++; $display("FAIL t2_next_mem_rd got %0b want 1", mem_rd); end
        n_checks++; if (mem_addr !== 16'h0101) begin n_fail++; $display("FAIL t2_next_mem_addr got %h want 0101", mem_addr); end
        mem_ack = 1'b1; mem_data = 16'h5A5A;
        @(negedge clock);
        mem_ack = 1'b0; run = 1'b0;
        n_checks++; if (ir_out !== 16'h5A5A) begin n_fail++; $display("FAIL t2_next_ir_out got %h want 5a5a", ir_out); end
        n_checks++; if (pc_inc !== 1'b1)     begin n_fail++; $display("FAIL t2_next_pc_inc got %0b want 1", pc_inc); end
    endtask
`endif

    task automatic test_wait_ack();
        do_reset();
        run = 1'b1; pc_in = 16'h0300;
        @(negedge clock);
        @(negedge clock);
        n_checks++; if (mem_rd !== 1'b1) begin n_fail++; $display("FAIL t3_first_mem_rd got %0b want 1", mem_rd); end
        for (int i = 1; i <= 3; i++) begin
            @(negedge clock);
            n_checks++; if (mem_rd !== 1'b1)       begin n_fail++; $display("FAIL t3_wait_mem_rd cyc %0d got %0b want 1", i, mem_rd); end
            n_checks++; if (mem_addr !== 16'h0300) begin n_fail++; $display("FAIL t3_wait_mem_addr cyc %0d got %h want 0300", i, mem_addr); end
            n_checks++; if (pc_inc !== 1'b0)       begin n_fail++; $display("FAIL t3_wait_pc_inc cyc %0d got %0b want 0", i, pc_inc); end
        end
        // Fourth read cycle is also the last one before timeout: ack must win.
        mem_ack = 1'b1; mem_data = 16'h3C3C;
        @(negedge clock);
        mem_ack = 1'b0; run = 1'b0;
        n_checks++; if (pc_inc !== 1'b1)     begin n_fail++; $display("FAIL t3_pc_inc got %0b want 1", pc_inc); end
        n_checks++; if (ir_out !== 16'h3C3C) begin n_fail++; $display("FAIL t3_ir_out got %h want 3c3c", ir_out); end
        n_checks++; if (bus_err !== 1'b0)    begin n_fail++; $display("FAIL t3_bus_err got %0b want 0", bus_err); end
        n_checks++; if (mem_rd !== 1'b0)     begin n_fail++; $display("FAIL t3_after_mem_rd got %0b want 0", mem_rd); end
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            n_checks++; if (pc_inc !== 1'b0) begin n_fail++; $display("FAIL t3_extra_pc_inc cyc %0d got %0b want 0", i, pc_inc); end
        end
    endtask

    task automatic test_timeout();
        do_reset();
        run = 1'b1; pc_in = 16'h0400;
        @(negedge clock);
        for (int i = 0; i < 4; i++) begin
            @(negedge clock);
            n_checks++; if (mem_rd !== 1'b1)  begin n_fail++; $display("FAIL t4_read_mem_rd cyc %0d got %0b want 1", i, mem_rd); end
            n_checks++; if (bus_err !== 1'b0) begin n_fail++; $display("FAIL t4_read_bus_err cyc %0d got %0b want 0", i, bus_err); end
        end
        for (int i = 0; i < 6; i++) begin
            @(negedge clock);
            n_checks++; if (mem_rd !== 1'b0)  begin n_fail++; $display("FAIL t4_err_mem_rd cyc %0d got %0b want 0", i, mem_rd); end
            n_checks++; if (bus_err !== 1'b1) begin n_fail++; $display("FAIL t4_err_bus_err cyc %0d got %0b want 1", i, bus_err); end
        end
    endtask

    task automatic test_flush_ack();
        do_reset();
        run = 1'b1; pc_in = 16'h1000;
        @(negedge clock);
        @(negedge clock);
        n_checks++; if (mem_addr !== 16'h1000) begin n_fail++; $display("FAIL t5_first_addr got %h want 1000", mem_addr); end
        mem_ack = 1'b1; mem_data = 16'hDEAD; flush = 1'b1; pc_in = 16'h2000;
        @(negedge clock);
        mem_ack = 1'b0; flush = 1'b0;
        n_checks++; if (pc_inc !== 1'b0)   begin n_fail++; $display("FAIL t5_flush_pc_inc got %0b want 0", pc_inc); end
        n_checks++; if (ir_valid !== 1'b0) begin n_fail++; $display("FAIL t5_flush_ir_valid got %0b want 0", ir_valid); end
        n_checks++; if (mem_rd !== 1'b0)   begin n_fail++; $display("FAIL t5_flush_mem_rd got %0b want 0", mem_rd); end
        @(negedge clock);
        n_checks++; if (mem_rd !== 1'b1)       begin n_fail++; $display("FAIL t5_new_mem_rd got %0b want 1", mem_rd); end
        n_checks++; if (mem_addr !== 16'h2000) begin n_fail++; $display("FAIL t5_new_addr got %h want 2000", mem_addr); end
        mem_ack = 1'b1; mem_data = 16'hBEEF;
        @(negedge clock);
        mem_ack = 1'b0; run = 1'b0;
        n_checks++; if (pc_inc !== 1'b1)     begin n_fail++; $display("FAIL t5_new_pc_inc got %0b want 1", pc_inc); end
        n_checks++; if (ir_out !== 16'hBEEF) begin n_fail++; $display("FAIL t5_new_ir_out got %h want beef", ir_out); end
    endtask

`ifdef IFETCH_PREFETCH_EN
    task automatic test_prefetch();
        logic [15:0] words [3];
        int widx;
        int got;
        int last_inc;
        int incs;
        int late_rd;
        words[0] = 16'h1111; words[1] = 16'h2222; words[2] = 16'h3333;
        widx = 0; got = 0; last_inc = -1;
        do_reset();
        run = 1'b1; ir_ready = 1'b1; pc_in = 16'h0600;
        for (int cyc = 1; cyc < 30; cyc++) begin
            @(negedge clock);
            mem_ack = 1'b0;
            if (ir_valid && ir_ready && got < 3) begin
                n_checks++; if (ir_out !== words[got]) begin n_fail++; $display("FAIL t6_order word %0d got %h want %h", got, ir_out, words[got]); end
                got++;
            end
            if (pc_inc) begin
                if (last_inc >= 0) begin
                    n_checks++; if (cyc - last_inc != 2) begin n_fail++; $display("FAIL t6_spacing got %0d want 2", cyc - last_inc); end
                end
                last_inc = cyc;
            end
            if (mem_rd && widx < 3) begin
                mem_ack = 1'b1; mem_data = words[widx]; widx++;
            end
            if (got == 3) break;
        end
        mem_ack = 1'b0; run = 1'b0;
        n_checks++; if (got != 3) begin n_fail++; $display("FAIL t6_accepted got %0d want 3", got); end

        do_reset();
        run = 1'b1; ir_ready = 1'b0; pc_in = 16'h0700;
        incs = 0; late_rd = 0; widx = 0;
        for (int cyc = 1; cyc < 20; cyc++) begin
            @(negedge clock);
            mem_ack = 1'b0;
            if (pc_inc) incs++;
            if (cyc >= 14 && mem_rd) late_rd++;
            if (mem_rd && widx < 4) begin
                mem_ack = 1'b1; mem_data = 16'h4444 + 16'(widx) * 16'h1111; widx++;
            end
        end
        mem_ack = 1'b0;
        n_checks++; if (incs != 2)    begin n_fail++; $display("FAIL t6_full_incs got %0d want 2", incs); end
        n_checks++; if (late_rd != 0) begin n_fail++; $display("FAIL t6_full_mem_rd got %0d want 0", late_rd); end
        n_checks++; if (ir_out !== 16'h4444) begin n_fail++; $display("FAIL t6_full_head got %h want 4444", ir_out); end
        ir_ready = 1'b1;
        @(negedge clock);
        ir_ready = 1'b0; run = 1'b0;
        n_checks++; if (ir_out !== 16'h5555) begin n_fail++; $display("FAIL t6_second got %h want 5555", ir_out); end
        n_checks++; if (ir_valid !== 1'b1)   begin n_fail++; $display("FAIL t6_second_valid got %0b want 1", ir_valid); end
    endtask
`endif

    // Random decoder stalls, memory latencies, flushes and PC values.
    task automatic test_random();
        logic [15:0] exp_q [$];
        logic [15:0] prev_pc;
        logic [15:0] rd_addr;
        logic        prev_rd;
        logic        prev_load;
        logic        ack;
        int          rd_cycles;
        int          delay;
        do_reset();
        run = 1'b1;
        pc_in = 16'($urandom);
        prev_pc = pc_in; prev_rd = 1'b0; prev_load = 1'b0;
        rd_addr = 16'h0000; rd_cycles = 0; delay = 0;
        for (int cyc = 0; cyc < 600; cyc++) begin
            @(negedge clock);
            n_checks++; if (bus_err !== 1'b0)   begin n_fail++; $display("FAIL rnd_bus_err cyc %0d got %0b want 0", cyc, bus_err); end
            n_checks++; if (pc_inc !== prev_load) begin n_fail++; $display("FAIL rnd_pc_inc cyc %0d got %0b want %0b", cyc, pc_inc, prev_load); end
            n_checks++; if (ir_valid !== (exp_q.size() != 0)) begin n_fail++; $display("FAIL rnd_ir_valid cyc %0d got %0b want %0b", cyc, ir_valid, exp_q.size() != 0); end
            if (mem_rd && !prev_rd) begin
                n_checks++; if (mem_addr !== prev_pc) begin n_fail++; $display("FAIL rnd_addr cyc %0d got %h want %h", cyc, mem_addr, prev_pc); end
                rd_addr = mem_addr; rd_cycles = 0; delay = $urandom_range(0, 3);
            end else if (mem_rd) begin
                n_checks++; if (mem_addr !== rd_addr) begin n_fail++; $display("FAIL rnd_addr_hold cyc %0d got %h want %h", cyc, mem_addr, rd_addr); end
                rd_cycles++;
            end
            if (mem_rd) begin
                n_checks++; if (exp_q.size() >= CAP) begin n_fail++; $display("FAIL rnd_rd_when_full cyc %0d got %0d want <%0d", cyc, exp_q.size(), CAP); end
            end
            ir_ready = ($urandom_range(0, 2) != 0);
            flush    = ($urandom_range(0, 15) == 0);
            pc_in    = 16'($urandom);
            mem_data = 16'($urandom);
            ack      = mem_rd && (rd_cycles == delay);
            mem_ack  = ack;
            if (ir_valid && ir_ready && exp_q.size() != 0) begin
                n_checks++; if (ir_out !== exp_q[0]) begin n_fail++; $display("FAIL rnd_word cyc %0d got %h want %h", cyc, ir_out, exp_q[0]); end
                void'(exp_q.pop_front());
            end
            if (flush) exp_q.delete();
            else if (ack) exp_q.push_back(mem_data);
            prev_load = ack && !flush;
            prev_pc   = pc_in;
            prev_rd   = mem_rd;
        end
        run = 1'b0; flush = 1'b0; mem_ack = 1'b0; ir_ready = 1'b0;
    endtask

    initial begin
        reset = 1'b1; run = 1'b0; flush = 1'b0; pc_in = 16'h0000;
        mem_ack = 1'b0; mem_data = 16'h0000; ir_ready = 1'b0;
        test_reset();
        test_single_fetch();
`ifndef IFETCH_PREFETCH_EN
        test_hold();
`endif
        test_wait_ack();
        test_timeout();
        test_flush_ack();
`ifdef IFETCH_PREFETCH_EN
        test_prefetch();
`endif
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // Hard stop if the sequence above ever stalls.
    initial begin
        #500000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
